// File: rtl/score4_ctrl.sv
// Connect-four game controller: button conditioning, drop/cursor FSM and 4-in-a-row evaluation.
// Optional input debounce filtering is enabled with `define DEBOUNCE_EN.
module score4_ctrl #(
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   left,
    input  logic                   right,
    input  logic                   put,
    output logic [6:0][5:0][1:0]   panel,
    output logic [6:0]             play,
    output logic                   turn,
    output logic                   player,
    output logic                   invalid_move,
    output logic                   win_a,
    output logic                   win_b,
    output logic                   full_panel
);

    localparam int unsigned NB = 3;
`ifdef DEBOUNCE_EN
    localparam logic [2:0] WARM = 3'd4;
`else
    localparam logic [2:0] WARM = 3'd3;
`endif

    typedef enum logic [1:0] {IDLE, CHECK, OVER} state_t;

    logic [NB-1:0] sync1_q, sync2_q, prev_q, level;
    logic [2:0]    warm_q, warm_d;
    logic          warm_done;
    logic [NB-1:0] rise_c;

    // Edges stay masked until the pipeline holds real samples, so a held button never fires.
    assign warm_done = (warm_q == WARM);
    assign warm_d    = warm_done ? warm_q : warm_q + 3'd1;
    assign rise_c    = warm_done ? (level & ~prev_q) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            warm_q  <= '0;
        end else begin
            sync1_q <= {put, right, left};
            sync2_q <= sync1_q;
            prev_q  <= level;
            warm_q  <= warm_d;
        end
    end

`ifdef DEBOUNCE_EN
    logic [NB-1:0]        filt_q, filt_d;
    logic [NB-1:0][19:0]  cnt_q, cnt_d;

    always_comb begin
        filt_d = filt_q;
        cnt_d  = cnt_q;
        for (int i = 0; i < NB; i++) begin
            if (!warm_done) begin
                filt_d[i] = sync2_q[i];
                cnt_d[i]  = '0;
            end else if (sync2_q[i] == filt_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] >= DEBOUNCE_CYCLES - 20'd1) begin
                filt_d[i] = sync2_q[i];
                cnt_d[i]  = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 20'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_q <= '0;
            cnt_q  <= '0;
        end else begin
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign level = filt_q;
`else
    logic unused_debounce;
    assign unused_debounce = ^DEBOUNCE_CYCLES;
    assign level = sync2_q;
`endif

    state_t               state_q, state_d;
    logic [6:0][5:0][1:0] panel_q, panel_d;
    logic [6:0]           play_q, play_d;
    logic                 turn_q, turn_d;
    logic                 inv_q, inv_d;
    logic                 win_a_q, win_a_d, win_b_q, win_b_d, full_q, full_d;
    logic [2:0]           col_c, row_c;
    logic                 col_full_c, board_full_c;
    logic [1:0]           hits_c;

    function automatic logic [1:0] four(input logic [1:0] a, input logic [1:0] b,
                                        input logic [1:0] c, input logic [1:0] d);
        four = (a == b && b == c && c == d) ? a : 2'b00;
    endfunction

    // Cursor column index and the landing row in that column.
    always_comb begin
        col_c = 3'd0;
        for (int c = 0; c < 7; c++)
            if (play_q[c]) col_c = 3'(c);
        row_c = 3'd0;
        for (int r = 5; r >= 0; r--)
            if (panel_q[col_c][r] == 2'b00) row_c = 3'(r);
        col_full_c = (panel_q[col_c][5] != 2'b00);
    end

    // Whole-board line scan; hits_c[0] = A has a line, hits_c[1] = B has a line.
    always_comb begin
        hits_c       = 2'b00;
        board_full_c = 1'b1;
        for (int c = 0; c < 7; c++)
            for (int r = 0; r < 6; r++)
                if (panel_q[c][r] == 2'b00) board_full_c = 1'b0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 6; r++)
                hits_c = hits_c | four(panel_q[c][r], panel_q[c+1][r], panel_q[c+2][r], panel_q[c+3][r]);
        for (int c = 0; c < 7; c++)
            for (int r = 0; r < 3; r++)
                hits_c = hits_c | four(panel_q[c][r], panel_q[c][r+1], panel_q[c][r+2], panel_q[c][r+3]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 3; r++)
                hits_c = hits_c | four(panel_q[c][r], panel_q[c+1][r+1], panel_q[c+2][r+2], panel_q[c+3][r+3]);
        for (int c = 0; c < 4; c++)
            for (int r = 3; r < 6; r++)
                hits_c = hits_c | four(panel_q[c][r], panel_q[c+1][r-1], panel_q[c+2][r-2], panel_q[c+3][r-3]);
    end

    always_comb begin
        state_d = state_q;
        panel_d = panel_q;
        play_d  = play_q;
        turn_d  = turn_q;
        inv_d   = 1'b0;
        win_a_d = win_a_q;
        win_b_d = win_b_q;
        full_d  = full_q;
        case (state_q)
            IDLE: begin
                if (rise_c[2]) begin
                    if (col_full_c) begin
                        inv_d = 1'b1;
                    end else begin
                        panel_d[col_c][row_c] = turn_q ? 2'b10 : 2'b01;
                        state_d = CHECK;
                    end
                end else if (rise_c[0] && !rise_c[1]) begin
                    play_d = {play_q[0], play_q[6:1]};
                end else if (rise_c[1] && !rise_c[0]) begin
                    play_d = {play_q[5:0], play_q[6]};
                end
            end
            CHECK: begin
                if (hits_c[0]) win_a_d = 1'b1;
                if (hits_c[1]) win_b_d = 1'b1;
                if (board_full_c) full_d = 1'b1;
                if (hits_c != 2'b00 || board_full_c) begin
                    state_d = OVER;
                end else begin
                    turn_d  = ~turn_q;
                    state_d = IDLE;
                end
            end
            OVER:    state_d = OVER;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            panel_q <= '0;
            play_q  <= 7'b0001000;
            turn_q  <= 1'b0;
            inv_q   <= 1'b0;
            win_a_q <= 1'b0;
            win_b_q <= 1'b0;
            full_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            panel_q <= panel_d;
            play_q  <= play_d;
            turn_q  <= turn_d;
            inv_q   <= inv_d;
            win_a_q <= win_a_d;
            win_b_q <= win_b_d;
            full_q  <= full_d;
        end
    end

    assign panel        = panel_q;
    assign play         = play_q;
    assign turn         = turn_q;
    assign player       = turn_q;
    assign invalid_move = inv_q;
    assign win_a        = win_a_q;
    assign win_b        = win_b_q;
    assign full_panel   = full_q;

endmodule

// File: tb/tb_score4_ctrl.sv
// Self-checking bench for score4_ctrl: vector table, directed game sequences and random play vs a board model.
module tb_score4_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic left = 1'b0, right = 1'b0, put = 1'b0;
    logic [6:0][5:0][1:0] panel;
    logic [6:0] play;
    logic turn, player, invalid_move, win_a, win_b, full_panel;

    score4_ctrl dut (
        .clk(clk), .rst(rst), .left(left), .right(right), .put(put),
        .panel(panel), .play(play), .turn(turn), .player(player),
        .invalid_move(invalid_move), .win_a(win_a), .win_b(win_b), .full_panel(full_panel)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int inv_cnt = 0;
    int win_cnt = 0;

    always @(negedge clk) begin
        if (invalid_move === 1'b1) inv_cnt++;
        if (win_a === 1'b1) win_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Board model: brd[col][row], 0 empty, 1 A, 2 B.
    int brd[7][6];
    int cur, mturn;
    bit m_wa, m_wb, m_full, m_over;

    function automatic void model_reset();
        for (int c = 0; c < 7; c++)
            for (int r = 0; r < 6; r++) brd[c][r] = 0;
        cur = 3; mturn = 0; m_wa = 0; m_wb = 0; m_full = 0; m_over = 0;
    endfunction

    function automatic bit model_line(int code);
        int dc[4] = '{1, 0, 1, 1};
        int dr[4] = '{0, 1, 1, -1};
        for (int c = 0; c < 7; c++)
            for (int r = 0; r < 6; r++)
                for (int d = 0; d < 4; d++) begin
                    int n = 0;
                    for (int k = 0; k < 4; k++) begin
                        int cc = c + k * dc[d];
                        int rr = r + k * dr[d];
                        if (cc >= 0 && cc < 7 && rr >= 0 && rr < 6 && brd[cc][rr] == code) n++;
                    end
                    if (n == 4) return 1'b1;
                end
        return 1'b0;
    endfunction

    // Returns the number of invalid_move cycles the command should produce.
    function automatic int model_apply(logic [2:0] b);
        int h, filled;
        bit a, bb;
        if (m_over) return 0;
        if (b[2]) begin
            h = 0;
            for (int r = 0; r < 6; r++) if (brd[cur][r] != 0) h++;
            if (h == 6) return 1;
            brd[cur][h] = (mturn != 0) ? 2 : 1;
            a = model_line(1);
            bb = model_line(2);
            filled = 0;
            for (int c = 0; c < 7; c++)
                for (int r = 0; r < 6; r++) if (brd[c][r] != 0) filled++;
            if (a) m_wa = 1;
            if (bb) m_wb = 1;
            if (filled == 42) m_full = 1;
            if (a || bb || filled == 42) m_over = 1;
            else mturn = 1 - mturn;
        end else if (b[0] && !b[1]) begin
            cur = (cur + 6) % 7;
        end else if (b[1] && !b[0]) begin
            cur = (cur + 1) % 7;
        end
        return 0;
    endfunction

    function automatic logic [6:0][5:0][1:0] model_panel();
        logic [6:0][5:0][1:0] p;
        for (int c = 0; c < 7; c++)
            for (int r = 0; r < 6; r++) p[c][r] = 2'(brd[c][r]);
        return p;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int exp_inv, input int got_inv);
        logic [6:0] ep;
        ep = 7'b0000001 << cur;
        chk({tag, " panel"}, 128'(panel), 128'(model_panel()));
        chk({tag, " play"}, 128'(play), 128'(ep));
        chk({tag, " turn"}, 128'(turn), 128'(mturn));
        chk({tag, " player"}, 128'(player), 128'(mturn));
        chk({tag, " win_a"}, 128'(win_a), 128'(m_wa));
        chk({tag, " win_b"}, 128'(win_b), 128'(m_wb));
        chk({tag, " full"}, 128'(full_panel), 128'(m_full));
        chk({tag, " inv_cycles"}, 128'(got_inv), 128'(exp_inv));
    endtask

    // Hold buttons across two rising edges, then leave idle time for CHECK to finish.
    task automatic press(input logic [2:0] b);
        @(negedge clk); {put, right, left} = b;
        @(negedge clk);
        @(negedge clk); {put, right, left} = 3'b000;
        repeat (5) @(negedge clk);
    endtask

    task automatic do_op(input string tag, input logic [2:0] b);
        int i0, ei;
        i0 = inv_cnt;
        press(b);
        ei = model_apply(b);
        check_all(tag, ei, inv_cnt - i0);
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1; {put, right, left} = 3'b000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (6) @(negedge clk);
    endtask

    task automatic goto_col(input int col);
        for (int i = 0; i < 7 && cur != col; i++) do_op("goto", 3'b010);
    endtask

    task automatic drop_at(input int col);
        goto_col(col);
        do_op("drop", 3'b100);
    endtask

    // Puts up to (not including) A's winning drop in column 3.
    task automatic setup_a_win();
        drop_at(0); drop_at(6); drop_at(1); drop_at(6); drop_at(2); drop_at(6);
        goto_col(3);
    endtask

    typedef struct {
        logic [2:0] btn;
        logic [6:0] play;
        logic       turn;
        int         inv;
    } vec_t;

    vec_t vt[19];
    int   fill_order[42];
    int   over_ops;

    initial begin
        // btn = {put, right, left}
        vt[0]  = '{3'b010, 7'b0010000, 1'b0, 0};
        vt[1]  = '{3'b010, 7'b0100000, 1'b0, 0};
        vt[2]  = '{3'b010, 7'b1000000, 1'b0, 0};
        vt[3]  = '{3'b010, 7'b0000001, 1'b0, 0};
        vt[4]  = '{3'b001, 7'b1000000, 1'b0, 0};
        vt[5]  = '{3'b011, 7'b1000000, 1'b0, 0};
        vt[6]  = '{3'b001, 7'b0100000, 1'b0, 0};
        vt[7]  = '{3'b001, 7'b0010000, 1'b0, 0};
        vt[8]  = '{3'b001, 7'b0001000, 1'b0, 0};
        vt[9]  = '{3'b100, 7'b0001000, 1'b1, 0};
        vt[10] = '{3'b100, 7'b0001000, 1'b0, 0};
        vt[11] = '{3'b100, 7'b0001000, 1'b1, 0};
        vt[12] = '{3'b100, 7'b0001000, 1'b0, 0};
        vt[13] = '{3'b100, 7'b0001000, 1'b1, 0};
        vt[14] = '{3'b100, 7'b0001000, 1'b0, 0};
        vt[15] = '{3'b100, 7'b0001000, 1'b0, 1};
        vt[16] = '{3'b110, 7'b0001000, 1'b0, 1};
        vt[17] = '{3'b010, 7'b0010000, 1'b0, 0};
        vt[18] = '{3'b101, 7'b0010000, 1'b1, 0};

        // Columns pattern X X Y Y X X Y (X bottom A, Y bottom B): no line of four anywhere.
        begin
            int k = 0;
            for (int i = 0; i < 6; i++) fill_order[k++] = 0;
            for (int i = 0; i < 6; i++) fill_order[k++] = 1;
            fill_order[k++] = 4;
            for (int i = 0; i < 6; i++) fill_order[k++] = 2;
            for (int i = 0; i < 6; i++) fill_order[k++] = 3;
            fill_order[k++] = 4;
            for (int i = 0; i < 4; i++) fill_order[k++] = 4;
            fill_order[k++] = 5;
            for (int i = 0; i < 6; i++) fill_order[k++] = 6;
            for (int i = 0; i < 5; i++) fill_order[k++] = 5;
        end

        // Reset values while rst is high.
        model_reset();
        repeat (3) @(negedge clk);
        check_all("reset", 0, 0);
        rst = 1'b0;
        repeat (6) @(negedge clk);

        // Cursor wrap, simultaneous ignore, drops, full column and put priority.
        for (int i = 0; i < 19; i++) begin
            int i0, ei;
            i0 = inv_cnt;
            press(vt[i].btn);
            ei = model_apply(vt[i].btn);
            chk($sformatf("vec%0d play", i), 128'(play), 128'(vt[i].play));
            chk($sformatf("vec%0d turn", i), 128'(turn), 128'(vt[i].turn));
            chk($sformatf("vec%0d inv", i), 128'(inv_cnt - i0), 128'(vt[i].inv));
            check_all($sformatf("vec%0d", i), ei, inv_cnt - i0);
        end
        chk("col3 row0 A", 128'(panel[3][0]), 128'(2'b01));
        chk("col3 row1 B", 128'(panel[3][1]), 128'(2'b10));

        // Held button across reset must not generate a drop.
        @(negedge clk); rst = 1'b1; put = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (10) @(negedge clk);
        put = 1'b0;
        repeat (5) @(negedge clk);
        check_all("held_put", 0, 0);

        // Right edge arriving during CHECK is discarded.
        @(negedge clk); put = 1'b1;
        @(negedge clk); right = 1'b1;
        @(negedge clk); put = 1'b0;
        @(negedge clk); right = 1'b0;
        repeat (6) @(negedge clk);
        void'(model_apply(3'b100));
        check_all("edge_in_check", 0, 0);

        // A wins along row 0 with exact latency; later commands are ignored.
        do_reset();
        setup_a_win();
        @(negedge clk); put = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        chk("lat k+1 panel", 128'(panel[3][0]), 128'(2'b00));
        @(negedge clk); put = 1'b0;
        @(posedge clk); #1;
        chk("lat k+2 panel", 128'(panel[3][0]), 128'(2'b01));
        chk("lat k+2 win_a", 128'(win_a), 128'(1'b0));
        @(posedge clk); #1;
        chk("lat k+3 win_a", 128'(win_a), 128'(1'b1));
        chk("lat k+3 turn", 128'(turn), 128'(1'b0));
        repeat (4) @(negedge clk);
        void'(model_apply(3'b100));
        check_all("a_win", 0, 0);
        do_op("over_put", 3'b100);
        do_op("over_left", 3'b001);
        do_op("over_put2", 3'b100);

        // Reset in the CHECK cycle of a winning move.
        do_reset();
        setup_a_win();
        @(negedge clk); put = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk); put = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("rst_in_check", 0, 0);
        begin
            int w0;
            w0 = win_cnt;
            repeat (3) @(negedge clk);
            rst = 1'b0;
            repeat (6) @(negedge clk);
            chk("rst_in_check win_a never", 128'(win_cnt - w0), 128'(0));
        end
        check_all("after_rst", 0, 0);

        // Fill the whole board without a line.
        for (int i = 0; i < 42; i++) drop_at(fill_order[i]);
        chk("full flag", 128'(full_panel), 128'(1'b1));
        chk("full win_a", 128'(win_a), 128'(1'b0));
        chk("full win_b", 128'(win_b), 128'(1'b0));
        do_op("full_over_put", 3'b100);

        // Random play against the model.
        do_reset();
        over_ops = 0;
        for (int i = 0; i < 300; i++) begin
            logic [2:0] b;
            if (m_over) begin
                over_ops++;
                if (over_ops > 3) begin
                    do_reset();
                    over_ops = 0;
                end
            end
            b = 3'($urandom_range(1, 7));
            do_op("rand", b);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/score4_ctrl.md
SCORE4_CTRL -- requirements
Module: score4_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 20'd500000, sets the stable-input cycle count used only when DEBOUNCE_EN is defined.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 left, right, put  input  1 each  raw level button inputs, asynchronous to clk.
REQ-005 panel  output  [6:0][5:0][1:0]  board as [column][row]; row 0 is the bottom; 2'b00 empty, 2'b01 player A, 2'b10 player B.
REQ-006 play  output  7  one-hot cursor column; bit 0 is the leftmost column.
REQ-007 turn  output  1  0 = player A to move, 1 = player B to move.
REQ-008 player  output  1  equals turn.
REQ-009 invalid_move  output  1  one-cycle pulse on a rejected drop.
REQ-010 win_a, win_b, full_panel  output  1 each  sticky game-end flags.

Function
REQ-011 Each button passes through a 2-flop synchronizer, then a rising-edge detector; only single-cycle edge pulses drive the FSM.
REQ-012 The FSM has three states: IDLE (accepts commands), CHECK (evaluates the board), and OVER (ignores all buttons until reset).
REQ-013 In IDLE, a left edge rotates play one column toward bit 0, wrapping from bit 0 to bit 6.
REQ-014 In IDLE, a right edge rotates play one column toward bit 6, wrapping from bit 6 to bit 0.
REQ-015 Simultaneous left and right edges are ignored.
REQ-016 A put edge has priority over left and right; the cursor holds for that cycle.
REQ-017 In IDLE, a put edge on a column with an empty cell writes the mover's code into the lowest empty row of that column and moves the FSM to CHECK.
REQ-018 In IDLE, a put edge on a full column (row 5 occupied) pulses invalid_move for exactly one cycle; panel, turn and state are unchanged.
REQ-019 CHECK lasts exactly one cycle and evaluates all horizontal, vertical and both diagonal 4-in-a-row lines over the whole board.
REQ-020 If CHECK finds 4 A cells in a line, win_a sets and the FSM moves to OVER; 4 B cells set win_b.
REQ-021 If all 42 cells are nonempty, full_panel sets and the FSM moves to OVER, even when a win flag also sets in the same cycle.
REQ-022 If CHECK finds no win and the board is not full, turn toggles and the FSM returns to IDLE.
REQ-023 turn does not toggle on a winning move.
REQ-024 Latency without debounce: a button high before edge k with its edge detected at edge k+2 updates play or panel at edge k+2; win and full flags update at edge k+3; turn updates at edge k+3.
REQ-025 Button edges arriving while in CHECK or OVER are discarded, not queued.

Reset
REQ-026 While rst is high: panel = all 2'b00, play = 7'b0001000, turn = 0, invalid_move = 0, win_a = win_b = full_panel = 0, FSM = IDLE, synchronizers and debounce counters cleared.
REQ-027 rst takes effect asynchronously at any state, including mid-CHECK.
REQ-028 After rst deasserts, no edge is generated for a button that is already held high.

Configuration
REQ-029 Macro DEBOUNCE_EN: when defined, each synchronized input updates its filtered level only after DEBOUNCE_CYCLES consecutive cycles at the new value; edge detection runs on the filtered level, which adds DEBOUNCE_CYCLES cycles to REQ-024 latency.
REQ-030 Without DEBOUNCE_EN, no counters are instantiated and edge detection runs directly on the synchronizer output.

Verification
REQ-031 After reset, three right pulses -> play = 7'b1000000; one more right pulse -> play = 7'b0000001; one left pulse -> play = 7'b1000000.
REQ-032 After reset, put in column 3 -> panel[3][0] = 2'b01 and turn = 1; a second put -> panel[3][1] = 2'b10 and turn = 0.
REQ-033 After six puts in column 3, a seventh put -> invalid_move high exactly 1 cycle; panel and turn unchanged.
REQ-034 A moves in columns 0,1,2,3 and B moves in column 6 between them -> win_a = 1 one cycle after the 4th A drop; later puts leave panel unchanged.
REQ-035 Fill the board in an order that gives no 4-in-a-row -> full_panel = 1 with win_a = win_b = 0 after the 42nd drop.
REQ-036 Assert rst during the CHECK cycle of a winning move -> all outputs return to their reset values immediately and win_a never asserts.
